// File: rtl/temporizador_nota_pkg.sv
// Shared definitions for the note timer and the melody controller:
// counter width, FSM encoding and note period constants (16 MHz clock).
package temporizador_nota_pkg;

  localparam int CNT_W_DEF      = 28;
  localparam int GAP_CYCLES_DEF = 800000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_PLAY   = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  // Full tone periods in clocks; 0 encodes a rest.
  localparam int unsigned NOTE_REST = 0;
  localparam int unsigned FA3       = 91632;
  localparam int unsigned FA3S      = 86486;
  localparam int unsigned SOL3      = 81633;
  localparam int unsigned SOL3S     = 77052;
  localparam int unsigned LA3       = 72727;
  localparam int unsigned LA3S      = 68646;
  localparam int unsigned SI3       = 64793;
  localparam int unsigned DO4       = 61155;
  localparam int unsigned DO4S      = 57724;
  localparam int unsigned RE4       = 54484;
  localparam int unsigned RE4S      = 51425;
  localparam int unsigned MI4       = 48539;
  localparam int unsigned FA4       = 45815;
  localparam int unsigned FA4S      = 43244;
  localparam int unsigned SOL4      = 40816;

endpackage

// File: rtl/temporizador_nota_gerador_tom.sv
// Square-wave generator: half-period counter plus toggle flip-flop,
// with load (latch period, restart low), enable and forced clear.
module temporizador_nota_gerador_tom
  import temporizador_nota_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W-1:0] period,
  output logic             audio
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] p_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      half  <= '0;
      p_cnt <= '0;
      audio <= 1'b0;
    end else if (clear) begin
      p_cnt <= '0;
      audio <= 1'b0;
    end else if (load) begin
      half  <= period >> 1;
      p_cnt <= '0;
      audio <= 1'b0;
    end else if (enable && (half != '0)) begin
      if (p_cnt == half - ONE) begin
        audio <= ~audio;
        p_cnt <= '0;
      end else begin
        p_cnt <= p_cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/temporizador_nota.sv
// Note timer: latches a note on Disparo, plays it for its duration and
// drops Duracao when done. Optional articulation gap via NOTE_GAP_EN.
module temporizador_nota
  import temporizador_nota_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
`ifdef NOTE_GAP_EN
  ,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
`endif
) (
  input  logic             Clk_in,
  input  logic             Rst_in,
  input  logic             Disparo,
  input  logic [CNT_W-1:0] Temp_in,
  input  logic [CNT_W-1:0] Freq_in,
  input  logic             Stop_in,
  output logic             Duracao,
  output logic             Audio_out,
  output logic             Fim_nota
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] t_cnt;
  logic             t_last;
  logic             tone_load, tone_en, tone_clr, fim_nx;

  assign t_last = (t_cnt <= ONE);

`ifdef NOTE_GAP_EN
  logic [CNT_W-1:0] g_cnt;
  logic             g_last;

  assign g_last = (g_cnt <= ONE);

  always_ff @(posedge Clk_in) begin
    if (Rst_in) begin
      g_cnt <= '0;
    end else if (state == ST_PLAY) begin
      g_cnt <= CNT_W'(GAP_CYCLES);
    end else if ((state == ST_GAP) && (g_cnt != '0)) begin
      g_cnt <= g_cnt - ONE;
    end
  end
`endif

  // NOTE: every signal driven here gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nx  = state;
    tone_load = 1'b0;
    tone_en   = 1'b0;
    tone_clr  = 1'b0;
    fim_nx    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (Disparo && !Stop_in) state_nx = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (Stop_in) begin
          state_nx = ST_IDLE;
          tone_clr = 1'b1;
        end else begin
          state_nx  = ST_PLAY;
          tone_load = 1'b1;
        end
      end
      ST_PLAY: begin
        if (Stop_in) begin
          state_nx = ST_IDLE;
          tone_clr = 1'b1;
        end else if (t_last) begin
          tone_clr = 1'b1;
`ifdef NOTE_GAP_EN
          state_nx = ST_GAP;
`else
          state_nx = ST_IDLE;
          fim_nx   = 1'b1;
`endif
        end else begin
          tone_en = 1'b1;
        end
      end
`ifdef NOTE_GAP_EN
      ST_GAP: begin
        if (Stop_in) begin
          state_nx = ST_IDLE;
        end else if (g_last) begin
          state_nx = ST_IDLE;
          fim_nx   = 1'b1;
        end
      end
`endif
      default: state_nx = ST_IDLE;
    endcase
  end

  // Duracao is a flop fed from next state, so it has no input-to-output path.
  always_ff @(posedge Clk_in) begin
    if (Rst_in) begin
      state    <= ST_IDLE;
      t_cnt    <= '0;
      Duracao  <= 1'b0;
      Fim_nota <= 1'b0;
    end else begin
      state    <= state_nx;
      Duracao  <= (state_nx != ST_IDLE);
      Fim_nota <= fim_nx;
      if (state == ST_SETTLE) begin
        t_cnt <= Temp_in;
      end else if ((state == ST_PLAY) && (t_cnt != '0)) begin
        t_cnt <= t_cnt - ONE;
      end
    end
  end

  temporizador_nota_gerador_tom #(
    .CNT_W(CNT_W)
  ) u_gerador_tom (
    .clk   (Clk_in),
    .rst   (Rst_in),
    .load  (tone_load),
    .enable(tone_en),
    .clear (tone_clr),
    .period(Freq_in),
    .audio (Audio_out)
  );

endmodule

// File: tb/tb_temporizador_nota.sv
// Self-checking bench for temporizador_nota: directed notes plus random
// notes, each checked cycle by cycle against an arithmetic note model.
module tb_temporizador_nota;

  localparam int W = 28;
`ifdef NOTE_GAP_EN
  localparam int GAP   = 4;
  localparam int GAP_E = 4;
`else
  localparam int GAP_E = 0;
`endif

  logic         clk = 1'b0;
  logic         rst, disparo, stop;
  logic [W-1:0] temp, freq;
  logic         duracao, audio, fim;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  temporizador_nota #(
    .CNT_W(W)
`ifdef NOTE_GAP_EN
    , .GAP_CYCLES(GAP)
`endif
  ) dut (
    .Clk_in   (clk),
    .Rst_in   (rst),
    .Disparo  (disparo),
    .Temp_in  (temp),
    .Freq_in  (freq),
    .Stop_in  (stop),
    .Duracao  (duracao),
    .Audio_out(audio),
    .Fim_nota (fim)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic expect3(input string tag, input logic d, input logic a, input logic f);
    check({tag, ".duracao"}, duracao, d);
    check({tag, ".audio"}, audio, a);
    check({tag, ".fim"}, fim, f);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plays one note from IDLE. Index e counts edges after the trigger:
  // e=0 settle, 1..P play, then GAP_E gap cycles, then idle with Fim_nota.
  task automatic play_note(input int t, input int f, input int stop_at,
                           input bit hold, input string tag);
    int p, h, last;
    logic exp_a;
    p    = (t < 1) ? 1 : t;
    h    = f / 2;
    last = p + GAP_E + 1;
    temp    = W'(t);
    freq    = W'(f);
    disparo = 1'b1;
    stop    = 1'b0;
    for (int e = 0; e <= last; e++) begin
      tick();
      if (e == 0) begin
        expect3($sformatf("%s.settle", tag), 1'b1, 1'b0, 1'b0);
      end else if (e <= p) begin
        exp_a = (h == 0) ? 1'b0 : logic'(((e - 1) / h) % 2);
        expect3($sformatf("%s.play%0d", tag, e), 1'b1, exp_a, 1'b0);
      end else if (e < last) begin
        expect3($sformatf("%s.gap%0d", tag, e - p), 1'b1, 1'b0, 1'b0);
      end else begin
        expect3($sformatf("%s.end", tag), 1'b0, 1'b0, 1'b1);
      end
      if (e == 0 && !hold) disparo = 1'b0;
      if (e == 1) begin
        temp = W'($urandom_range(0, 60));
        freq = W'($urandom_range(0, 30));
      end
      if (e == stop_at) begin
        stop = 1'b1;
        tick();
        expect3($sformatf("%s.stopped", tag), 1'b0, 1'b0, 1'b0);
        stop = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    int t, f, p, s;
    bit h;

    rst = 1'b1; disparo = 1'b1; stop = 1'b0; temp = W'(5); freq = W'(4);
    repeat (3) begin
      tick();
      expect3("reset", 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    tick();
    check("reset_release.settle", duracao, 1'b1);
    stop = 1'b1; disparo = 1'b0;
    tick();
    expect3("stop_settle", 1'b0, 1'b0, 1'b0);
    stop = 1'b0;
    tick();
    expect3("idle", 1'b0, 1'b0, 1'b0);

    play_note(20, 8, -1, 1'b0, "basic");
    play_note(10, 0, -1, 1'b0, "rest");
    play_note(0, 8, -1, 1'b0, "zero_dur");
    play_note(12, 6, -1, 1'b1, "b2b_a");
    play_note(12, 10, -1, 1'b0, "b2b_b");
    play_note(100, 8, 5, 1'b0, "stop_play");
    play_note(9, 7, -1, 1'b0, "odd_freq");
    play_note(6, 2, -1, 1'b0, "half_one");
    play_note(5, 1, -1, 1'b0, "freq_one");
    play_note(3, 4, 3, 1'b0, "stop_terminal");

    disparo = 1'b1; stop = 1'b1;
    repeat (2) begin
      tick();
      expect3("stop_idle", 1'b0, 1'b0, 1'b0);
    end
    disparo = 1'b0; stop = 1'b0;

    disparo = 1'b1; temp = W'(50); freq = W'(4);
    tick();
    disparo = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    expect3("reset_mid", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    expect3("reset_mid_after", 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      t = $urandom_range(0, 30);
      f = $urandom_range(0, 16);
      p = (t < 1) ? 1 : t;
      s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, p + GAP_E)) : -1;
      h = (i < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
      play_note(t, f, s, h, $sformatf("rnd%0d", i));
    end

    disparo = 1'b0;
    tick();
    expect3("final_idle", 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
